// File: rtl/prince_ti_sbox_seq.sv
// Nibble-serial sequencer around a 2-share threshold-implementation PRINCE S-box.
// Optional build macro TI_SBOX_REMASK_EN adds rnd_i, which remasks both result shares.
module prince_ti_sbox_seq #(
  parameter int NIBBLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [4*NIBBLES-1:0] state1_i,
  input  logic [4*NIBBLES-1:0] state2_i,
`ifdef TI_SBOX_REMASK_EN
  input  logic [3:0]           rnd_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4*NIBBLES-1:0] state1_o,
  output logic [4*NIBBLES-1:0] state2_o
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  // S-box entry v lives in bits 4v+3:4v
  localparam logic [63:0] SBOX_TABLE = 64'h4D5E_0876_19CA_23FB;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    in1_p0, in2_p0;
  logic [3:0]      nib1_p0, nib2_p0;
  logic [31:0]     exp_p1;
  logic            vld_p1;
  logic [CW-1:0]   idx_p1;
  logic [3:0]      cmp1_p1, cmp2_p1, mask_p1;
  logic [W-1:0]    res1, res2;

  // Algebraic normal form of one S-box output bit (Moebius transform of its truth table).
  function automatic logic [15:0] anf_of(input int j);
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = SBOX_TABLE[4*v + j];
    for (int b = 0; b < 4; b++)
      for (int v = 0; v < 16; v++)
        if (((v >> b) & 1) == 1) t[v] = t[v] ^ t[v - (1 << b)];
    return t;
  endfunction

  // Input-share choice of expanded share s for {x,y,z,w}; any three of these are independent.
  function automatic logic [3:0] share_sel(input int s);
    logic [2:0] k;
    k = 3'(s);
    return {k[2], k[1], k[0], ^k};
  endfunction

  // A monomial term goes only into the lowest-numbered share that picks its share pattern.
  function automatic logic is_canon(input int m, input int s);
    logic [3:0] ms;
    logic [3:0] own;
    ms  = 4'(m);
    own = share_sel(s);
    for (int p = 0; p < s; p++)
      if (((share_sel(p) ^ own) & ms) == 4'b0) return 1'b0;
    return 1'b1;
  endfunction

  // Slice j -> eight expanded shares; share s sees exactly one share of every input variable.
  function automatic logic [31:0] ti_expand(input logic [3:0] a, input logic [3:0] b);
    logic [31:0] e;
    logic [15:0] anf;
    logic [3:0]  sel, u;
    logic        f;
    e = '0;
    for (int j = 0; j < 4; j++) begin
      anf = anf_of(j);
      for (int s = 0; s < 8; s++) begin
        sel = share_sel(s);
        u   = (a & ~sel) | (b & sel);
        f   = 1'b0;
        for (int m = 0; m < 16; m++)
          if (anf[m] && is_canon(m, s) && ((u & 4'(m)) == 4'(m))) f = ~f;
        e[8*j + s] = f;
      end
    end
    return e;
  endfunction

`ifdef TI_SBOX_REMASK_EN
  assign mask_p1 = rnd_i;
`else
  assign mask_p1 = 4'h0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: captured input shares, nibble selection
  assign nib1_p0 = in1_p0[4*int'(cnt) +: 4];
  assign nib2_p0 = in2_p0[4*int'(cnt) +: 4];

  // Stage p1: expanded-share register is the glitch barrier; compression reads only it
  always_comb begin
    cmp1_p1 = '0;
    cmp2_p1 = '0;
    for (int j = 0; j < 4; j++) begin
      cmp1_p1[j] = ^exp_p1[8*j +: 4];
      cmp2_p1[j] = ^exp_p1[8*j + 4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      in1_p0 <= '0;
      in2_p0 <= '0;
      exp_p1 <= '0;
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      res1   <= '0;
      res2   <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= (state == RUN);
      if (state == IDLE && start_i) begin
        in1_p0 <= state1_i;
        in2_p0 <= state2_i;
        cnt    <= '0;
      end
      if (state == RUN) begin
        exp_p1 <= ti_expand(nib1_p0, nib2_p0);
        idx_p1 <= cnt;
        if (cnt != LAST) cnt <= cnt + 1'b1;
      end
      if (vld_p1) begin
        res1[4*int'(idx_p1) +: 4] <= cmp1_p1 ^ mask_p1;
        res2[4*int'(idx_p1) +: 4] <= cmp2_p1 ^ mask_p1;
      end
    end
  end

  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);
  assign state1_o = res1;
  assign state2_o = res2;

endmodule
